// File: rtl/cf_i2s_pkg.sv
// Shared definitions for the CF_I2S transmit path: frame geometry, serial
// format select and the stereo frame record held in the FIFO.
package cf_i2s_pkg;

  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);

  typedef enum logic {
    I2S            = 1'b0,
    LEFT_JUSTIFIED = 1'b1
  } fmt_e;

  typedef struct packed {
    logic [SLOT_BITS-1:0] left;
    logic [SLOT_BITS-1:0] right;
  } frame_t;

  // Serial bit for slot position idx: MSB of the ss+1 bit sample first,
  // zero padding once the sample is exhausted.
  function automatic logic slot_bit(input logic [SLOT_BITS-1:0] sample,
                                    input logic [4:0]           ss,
                                    input logic [4:0]           idx);
    if (idx <= ss) begin
      return sample[ss - idx];
    end
    return 1'b0;
  endfunction

  // Word select for frame position pos. I2S leads the data by one bit.
  function automatic logic ws_bit(input fmt_e fmt, input logic [POS_W-1:0] pos);
    logic [POS_W-1:0] nxt;
    nxt = pos + 1'b1;
    return (fmt == I2S) ? nxt[POS_W-1] : pos[POS_W-1];
  endfunction

endpackage

// File: rtl/cf_i2s_tx_if.sv
// Stereo sample stream into the I2S transmitter (valid/ready handshake).
interface cf_i2s_tx_if;
  import cf_i2s_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [SLOT_BITS-1:0] in_left;
  logic [SLOT_BITS-1:0] in_right;

  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready
  );

endinterface

// File: rtl/cf_i2s_tx_fifo.sv
// Synchronous frame FIFO for the I2S transmitter. Pushes when full and pops
// when empty are ignored; no bypass path from write to read.
module cf_i2s_tx_fifo
  import cf_i2s_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  frame_t           wdata,
  input  logic             pop,
  output frame_t           rdata,
  output logic [FIFO_AW:0] level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  frame_t             mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Level never exceeds DEPTH, so its top bit alone marks full.
  assign full    = level[FIFO_AW];
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cf_i2s_tx.sv
// I2S master transmitter: buffers stereo frames from a valid/ready stream and
// serialises them on sck/ws/sdo as 64-bit frames of two 32-bit slots, in I2S
// or left-justified format.
module cf_i2s_tx
  import cf_i2s_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic [7:0]       prescale,
  input  logic [4:0]       sample_size,
  input  logic             left_justify,
  cf_i2s_tx_if.slave       stream,
  output logic             sck,
  output logic             ws,
  output logic             sdo,
  output logic [FIFO_AW:0] fifo_level,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             underflow
);

  logic [7:0]       cnt;
  logic [7:0]       ps_q;
  logic [POS_W-1:0] p;
  logic [POS_W-1:0] p_next;
  logic [4:0]       ss;
  frame_t           hold;
  frame_t           fifo_rdata;
  frame_t           push_data;
  logic             push;
  logic             tick;
  logic             fall;
  logic             frame_start;
  logic [4:0]       ss_eff;
  frame_t           hold_eff;
  logic [31:0]      sample_eff;
  logic             sdo_next;

  assign stream.in_ready = !fifo_full;
  assign push            = stream.in_valid && !fifo_full;
  assign push_data       = '{left: stream.in_left, right: stream.in_right};

  assign tick        = en && (cnt == ps_q);
  assign fall        = tick && sck;
  assign p_next      = p + 1'b1;
  assign frame_start = fall && (p_next == '0);

  cf_i2s_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (push_data),
    .pop   (frame_start),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next serial bit. At frame start the first bit must come from the frame
  // being popped in the same clock, so the freshly loaded values are used.
  always_comb begin
    ss_eff   = ss;
    hold_eff = hold;
    if (frame_start) begin
      ss_eff   = sample_size;
      hold_eff = fifo_empty ? '0 : fifo_rdata;
    end
    sample_eff = p_next[POS_W-1] ? hold_eff.right : hold_eff.left;
    sdo_next   = slot_bit(sample_eff, ss_eff, p_next[4:0]);
  end

  // Prescaler and bit clock; prescale is sampled only at wrap so a new value
  // never truncates a half period in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      ps_q <= '0;
      sck  <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      ps_q <= prescale;
      sck  <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      ps_q <= prescale;
      sck  <= ~sck;
    end else begin
      cnt  <= cnt + 8'd1;
    end
  end

  // Frame position, holding registers and ws/sdo, all advanced on sck falls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p         <= '1;
      ss        <= '0;
      hold      <= '0;
      ws        <= 1'b0;
      sdo       <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (!en) begin
        p   <= '1;
        ws  <= 1'b0;
        sdo <= 1'b0;
      end else if (fall) begin
        p   <= p_next;
        ws  <= ws_bit(fmt_e'(left_justify), p_next);
        sdo <= sdo_next;
        if (frame_start) begin
          ss        <= ss_eff;
          hold      <= hold_eff;
          underflow <= fifo_empty;
        end
      end
    end
  end

endmodule

// File: tb/tb_cf_i2s_tx.sv
// Self-checking bench for cf_i2s_tx: a stimulus process feeds the stream and
// configuration; a monitor keeps a frame queue model, reassembles each serial
// frame from sdo/ws and compares it with the model's expected slot words.
module tb_cf_i2s_tx;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic        clk          = 1'b0;
  logic        rst          = 1'b0;
  logic        en           = 1'b0;
  logic [7:0]  prescale     = 8'd1;
  logic [4:0]  sample_size  = 5'd15;
  logic        left_justify = 1'b0;
  logic        sck;
  logic        ws;
  logic        sdo;
  logic        fifo_full;
  logic        fifo_empty;
  logic        underflow;
  logic [AW:0] fifo_level;

  cf_i2s_tx_if bus ();

  cf_i2s_tx #(
    .FIFO_AW (AW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en           (en),
    .prescale     (prescale),
    .sample_size  (sample_size),
    .left_justify (left_justify),
    .stream       (bus),
    .sck          (sck),
    .ws           (ws),
    .sdo          (sdo),
    .fifo_level   (fifo_level),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nfail = 0;
  logic [63:0] mq[$];
  logic [63:0] cur_frame = '0;
  int          cur_bits = 1;
  logic        cur_lj = 1'b0;
  logic [63:0] cap_sdo = '0;
  logic [63:0] cap_ws = '0;
  logic [63:0] last_sdo = '0;
  logic [63:0] last_ws = '0;
  int          mp = 63;
  int          frames_done = 0;
  int          uf_seen = 0;
  int          gcyc = 0;
  int          last_start = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slot content: low 'bits' bits of the sample, MSB-first at the slot top.
  function automatic logic [31:0] slot_word(input logic [31:0] s, input int bits);
    logic [63:0] v;
    v = {32'd0, s} & ((64'd1 << bits) - 64'd1);
    v = v << (32 - bits);
    return v[31:0];
  endfunction

  // ws level at each of the 64 frame positions, position 0 in the MSB.
  function automatic logic [63:0] ws_pattern(input logic lj);
    logic [63:0] w;
    for (int k = 0; k < 64; k++) begin
      w[63-k] = lj ? (k >= 32) : (((k + 1) % 64) >= 32);
    end
    return w;
  endfunction

  initial begin : monitor
    logic       v;
    logic       e;
    logic       r;
    logic       lj;
    logic       exp_uf;
    logic       prev_sck;
    logic [63:0] d;
    logic [4:0] ssz;
    logic [7:0] psc;
    logic [AW:0] lvl;
    int         pre;
    int         hcyc;
    prev_sck = 1'b0;
    hcyc     = 0;
    forever begin
      @(posedge clk);
      v   = bus.in_valid;
      d   = {bus.in_left, bus.in_right};
      e   = en;
      r   = rst;
      ssz = sample_size;
      lj  = left_justify;
      psc = prescale;
      pre = mq.size();
      #1;
      gcyc++;
      exp_uf = 1'b0;
      if (r) begin
        mq.delete();
        mp = 63;
        prev_sck = 1'b0;
        hcyc = 0;
        last_start = -1;
      end else begin
        if (!e) begin
          check("idle_pins", {61'd0, sck, ws, sdo}, 64'd0);
          mp = 63;
          prev_sck = 1'b0;
          hcyc = 0;
          last_start = -1;
        end else begin
          hcyc++;
          if (sck !== prev_sck) begin
            check("sck_half_period", 64'(hcyc), 64'(int'(psc) + 1));
            hcyc = 0;
          end
          if (prev_sck && !sck) begin
            mp = (mp + 1) % 64;
            if (mp == 0) begin
              if (last_start >= 0) begin
                check("frame_period", 64'(gcyc - last_start), 64'(128 * (int'(psc) + 1)));
              end
              last_start = gcyc;
              if (mq.size() > 0) begin
                cur_frame = mq.pop_front();
              end else begin
                cur_frame = '0;
                exp_uf = 1'b1;
              end
              cur_bits = int'(ssz) + 1;
              cur_lj = lj;
            end
            cap_sdo[63-mp] = sdo;
            cap_ws[63-mp]  = ws;
            if (mp == 63) begin
              last_sdo = cap_sdo;
              last_ws  = cap_ws;
              check("frame_sdo", cap_sdo,
                    {slot_word(cur_frame[63:32], cur_bits), slot_word(cur_frame[31:0], cur_bits)});
              check("frame_ws", cap_ws, ws_pattern(cur_lj));
              frames_done++;
            end
          end
          prev_sck = sck;
        end
        if (underflow) uf_seen++;
        check("underflow", {63'd0, underflow}, {63'd0, exp_uf});
        if (v && pre < DEPTH) mq.push_back(d);
        lvl = (AW + 1)'(mq.size());
        check("fifo_flags", {58'd0, bus.in_ready, fifo_full, fifo_empty, fifo_level},
              {58'd0, mq.size() < DEPTH, mq.size() == DEPTH, mq.size() == 0, lvl});
      end
    end
  end

  task automatic offer(input logic [31:0] l, input logic [31:0] r);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_left  = l;
    bus.in_right = r;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_random(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(99) < pct) begin
        bus.in_valid = 1'b1;
        bus.in_left  = $urandom;
        bus.in_right = $urandom;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    target = frames_done + n;
    for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
    nvec++;
    if (frames_done < target) begin
      nfail++;
      $display("FAIL wait_frames: got %0d frames, want %0d", frames_done, target);
    end
  endtask

  task automatic wait_pos(input int pos, input int budget);
    for (int i = 0; i < budget && mp != pos; i++) @(negedge clk);
    nvec++;
    if (mp != pos) begin
      nfail++;
      $display("FAIL wait_pos: got %0d, want %0d", mp, pos);
    end
  endtask

  initial begin : driver
    int uf0;
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_pins", {60'd0, sck, ws, sdo, underflow}, 64'd0);
    check("rst_flags", {58'd0, bus.in_ready, fifo_full, fifo_empty, fifo_level}, 64'b101000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // I2S, 16-bit samples
    prescale = 8'd1; sample_size = 5'd15; left_justify = 1'b0;
    offer(32'h0000_A5F0, 32'h0000_1234);
    @(negedge clk); en = 1'b1;
    wait_frames(1, 1000);
    en = 1'b0;
    check("i2s_sdo", last_sdo, 64'hA5F0_0000_1234_0000);
    check("i2s_ws", last_ws, 64'h0000_0001_FFFF_FFFE);

    // Left-justified, same data
    left_justify = 1'b1;
    offer(32'h0000_A5F0, 32'h0000_1234);
    @(negedge clk); en = 1'b1;
    wait_frames(1, 1000);
    en = 1'b0;
    check("lj_sdo", last_sdo, 64'hA5F0_0000_1234_0000);
    check("lj_ws", last_ws, 64'h0000_0000_FFFF_FFFF);

    // Underflow cadence with an empty FIFO
    prescale = 8'd0; left_justify = 1'b0;
    uf0 = uf_seen;
    @(negedge clk); en = 1'b1;
    wait_frames(3, 2000);
    en = 1'b0;
    check("underflow_pulses", 64'(uf_seen - uf0), 64'd3);
    check("underflow_sdo", last_sdo, 64'd0);

    // Full FIFO and ordering
    prescale = 8'd1; sample_size = 5'($urandom);
    for (int i = 0; i < 5; i++) offer($urandom, $urandom);
    check("full_state", {59'd0, bus.in_ready, fifo_full, fifo_level}, {59'd0, 1'b0, 1'b1, 3'd4});
    @(negedge clk); en = 1'b1;
    wait_frames(5, 5000);
    en = 1'b0;

    // Enable dropped mid-frame, then restart with the next entry
    sample_size = 5'd31;
    for (int i = 0; i < 3; i++) offer($urandom, $urandom);
    @(negedge clk); en = 1'b1;
    wait_pos(40, 2000);
    en = 1'b0;
    @(negedge clk);
    check("drop_pins", {61'd0, sck, ws, sdo}, 64'd0);
    check("drop_level", 64'(fifo_level), 64'd2);
    @(negedge clk); en = 1'b1;
    wait_frames(2, 2000);
    en = 1'b0;

    // Randomised configuration, data and push timing
    for (int rnd = 0; rnd < 8; rnd++) begin
      prescale     = 8'($urandom_range(3));
      sample_size  = 5'($urandom);
      left_justify = 1'($urandom_range(1));
      run_random($urandom_range(6), 90);
      @(negedge clk); en = 1'b1;
      run_random($urandom_range(200, 512 * (int'(prescale) + 1)), 3);
      en = 1'b0;
    end

    // Asynchronous reset in the middle of a frame
    prescale = 8'd1; sample_size = 5'd23; left_justify = 1'b0;
    offer($urandom, $urandom);
    offer($urandom, $urandom);
    @(negedge clk); en = 1'b1;
    run_random(300, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_pins", {60'd0, sck, ws, sdo, underflow}, 64'd0);
    check("midrst_flags", {58'd0, bus.in_ready, fifo_full, fifo_empty, fifo_level}, 64'b101000);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    offer(32'h00AB_CDEF, 32'h0012_3456);
    @(negedge clk); en = 1'b1;
    wait_frames(1, 1000);
    en = 1'b0;
    check("post_rst_sdo", last_sdo, 64'hABCD_EF00_1234_5600);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cf_i2s_tx.md
# cf_i2s_tx

I2S master transmitter, the transmit counterpart of the CF_I2S receiver. Accepts stereo sample pairs over a valid/ready stream into a small FIFO and serialises them on `sck`/`ws`/`sdo` in standard I2S or left-justified format. It uses fixed 64-bit frames, with two 32-bit slots per frame. It sits behind a bus wrapper that drives the configuration inputs; the serial pins connect to a DAC/codec or, in verification, loop back into the CF_I2S receiver.

## Interface
- `FIFO_AW`, default 2: FIFO address width; depth is 2^FIFO_AW frames.
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `en`  in  1  transmitter enable; 0 stops serial output and holds the frame counter.
- `prescale`  in  8  half-period of `sck` in `clk_i` cycles, minus 1.
- `sample_size`  in  5  bits per sample minus 1 (0..31 gives 1..32 bits).
- `left_justify`  in  1  0 selects I2S format; 1 selects left-justified format.
- `in_valid`  in  1  stream valid.
- `in_ready`  out  1  stream ready; equals `!fifo_full`.
- `in_left`  in  32  left sample, LSB-aligned.
- `in_right`  in  32  right sample, LSB-aligned.
- `sck`  out  1  serial bit clock.
- `ws`  out  1  word select: 0 = left, 1 = right.
- `sdo`  out  1  serial data, MSB first.
- `fifo_level`  out  FIFO_AW+1  number of frames in the FIFO.
- `fifo_full`  out  1  FIFO full flag.
- `fifo_empty`  out  1  FIFO empty flag.
- `underflow`  out  1  one-cycle pulse when a frame starts with the FIFO empty.

## Operation
- **Push:** occurs when `in_valid && in_ready`; `{in_left, in_right}` is written to the FIFO.
- **Prescaler:** counts 0..`prescale`. At terminal count it wraps to 0 and toggles `sck`. `sck` period is 2*(prescale+1) clocks; `sck` idles low.
- **Frame position:** `p` (6 bits) advances on every `sck` falling edge, wrapping 63 to 0.
  - Channel is `p[5]`; bit index within the slot is `i = p[4:0]`.
- **Frame start** (falling edge where `p` becomes 0):
  - Pop one FIFO entry into the left/right holding registers.
  - Latch `sample_size` into `ss`.
  - If the FIFO is empty, load zeros and pulse `underflow`.
- **Data:** at each falling edge, `sdo` = sample[ss-i] when i <= ss, else 0. Sample is left when `p[5]`=0, right when `p[5]`=1.
- **Word select, I2S mode:** `ws` = ((p+1) mod 64) >= 32, so `ws` changes one bit period before the MSB.
- **Word select, left-justified mode:** `ws` = `p[5]`, so `ws` changes together with the MSB.
- **Disabled (`en`=0):**
  - Prescaler is cleared and `p` is forced to 63.
  - `sck`, `ws` and `sdo` are all 0.
  - FIFO contents are retained and pushes are still accepted.
- **Enable rising:** the first `sck` edge is rising, after prescale+1 clocks. The following falling edge starts frame 0.
- **Configuration changes:**
  - `left_justify` is used live; software changes it only while `en`=0.
  - `prescale` takes effect at the next prescaler wrap.

## Timing
- **Reset values:** all outputs 0 except `in_ready`=1 and `fifo_empty`=1. FIFO is cleared, `p`=63, prescaler=0.
- **Output registers:** `sck`, `ws` and `sdo` are registered. `ws` and `sdo` update in the same clock in which `sck` falls, so the receiver samples stable data on the rising edge.
- **Flag latency:** push-to-`fifo_level` is 1 clock. Pop updates `fifo_level` in the clock following the frame-start falling edge.
- **Push and pop in the same cycle while not full:** level unchanged.
- **Empty FIFO:** no bypass. A push in the same cycle as a frame-start pop does not satisfy that pop; `underflow` fires.
- **Full FIFO:** `in_ready`=0 and the push is ignored. A pop in that cycle frees space visible on the next clock.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronous).
- **`en` deasserted mid-frame:** outputs go to 0 on the next clock. The partially sent frame is discarded, not re-queued.

## Structure
- Package `cf_i2s_pkg` holds:
  - `FRAME_BITS`=64 and `SLOT_BITS`=32.
  - The format enum (`I2S`, `LEFT_JUSTIFIED`).
  - The frame struct `{left[31:0], right[31:0]}`.
- One sub-module, `cf_i2s_tx_fifo`: a synchronous FIFO, 64 bits wide and 2^FIFO_AW deep, with level, full and empty outputs.
- Top level contains the prescaler, frame counter, holding/shift logic and output registers.

## Test plan
- **Reset:** assert `rst_i` mid-operation. Expect `sck`=`ws`=`sdo`=0, `in_ready`=1, `fifo_level`=0 and `underflow`=0 asynchronously.
- **I2S, 16-bit:**
  - Setup: `prescale`=1, `sample_size`=15, push L=0xA5F0, R=0x1234, then enable.
  - `sck` period is 4 clocks.
  - Left slot: `sdo` = 1010_0101_1111_0000 followed by 16 zeros.
  - `ws` rises one bit before right bit 0x1234's MSB; the right slot mirrors the left.
- **Left-justified, same data:** `ws` toggles on the same falling edge as each MSB. `sdo` sequence is otherwise identical.
- **Underflow:** enable with an empty FIFO and `prescale`=0. Expect `sdo` constantly 0 and exactly one `underflow` pulse every 128 clocks.
- **Full FIFO and ordering:**
  - With `en`=0, push 5 frames. Expect `fifo_full`=1 and `in_ready`=0 after the 4th; the 5th is not accepted.
  - Then enable. Frames 1-4 are transmitted in order, followed by underflow.
- **Enable drop mid-frame:**
  - Deassert `en` at p=40. Expect all outputs 0 within 1 clock and `fifo_level` unchanged.
  - Re-enable. Transmission restarts at p=0 with the next FIFO entry.
